// File: rtl/diff_freq_pkg.sv
// Shared definitions for the diff_freq_channel serial output engine:
// FSM state encodings, field widths and the captured command-field record.
package diff_freq_pkg;

  localparam int unsigned PERIOD_W = 8;
  localparam int unsigned SEL_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Timing and mode fields of a decoded command (patterns are sized per instance)
  typedef struct packed {
    logic                mode;
    logic [PERIOD_W-1:0] slow;
    logic [PERIOD_W-1:0] fast;
  } cmd_cfg_t;

endpackage

// File: rtl/diff_freq_channel_bit_timer.sv
// bit_timer: 8-bit loadable down-counter timing one serial bit.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val (takes priority over en)
//   load_val  : remaining clocks of the new bit (period)
//   en        : count down one step
//   cnt       : current count
//   zero      : registered flag, high while the count sits at 0 and the timer is active
module bit_timer
  import diff_freq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                en,
  output logic [PERIOD_W-1:0] cnt,
  output logic                zero
);

  // zero drops whenever the timer is neither loaded nor enabled, so it reads 0 outside a run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      zero <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      zero <= (load_val == '0);
    end else if (en) begin
      if (cnt != '0) cnt <= cnt - PERIOD_W'(1);
      zero <= (cnt <= PERIOD_W'(1));
    end else begin
      zero <= 1'b0;
    end
  end

endmodule

// File: rtl/diff_freq_channel.sv
// diff_freq_channel: per-channel serial output engine behind the UART command decoder.
// Captures commands addressed to CHANNEL_ID and shifts the output pattern out LSB-first,
// each bit held slow_period+1 or fast_period+1 clocks as chosen by the frequency pattern.
// Optional macro DIFF_FREQ_SHADOW_EN: config-only commands received while running are
// held in a shadow set and applied at the next continuous-mode wrap.
// Ports:
//   clk, rst            : clock, async active-high reset
//   i_done_tick         : decoder command-valid strobe
//   i_output_pattern    : bit values to emit
//   i_freq_pattern      : per bit, 1 = fast period, 0 = slow period
//   i_sel_out           : channel address
//   i_start, i_stop     : start / stop commands (stop wins)
//   i_mode              : 0 = one-shot, 1 = continuous
//   i_slow_period       : slow bit length minus 1
//   i_fast_period       : fast bit length minus 1
//   o_serial_out        : registered serial output
//   o_bit_tick          : high on the last clock of each bit
//   o_busy              : high while running
//   o_done_tick         : one-cycle pulse at the end of each pass
module diff_freq_channel
  import diff_freq_pkg::*;
#(
  parameter int unsigned DATA_BIT   = 32,
  parameter int unsigned CHANNEL_ID = 0,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_done_tick,
  input  logic [DATA_BIT-1:0] i_output_pattern,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic [SEL_W-1:0]    i_sel_out,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  input  logic [PERIOD_W-1:0] i_slow_period,
  input  logic [PERIOD_W-1:0] i_fast_period,
  output logic                o_serial_out,
  output logic                o_bit_tick,
  output logic                o_busy,
  output logic                o_done_tick
);

  localparam int unsigned IDX_W = $clog2(DATA_BIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BIT - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_BIT-1:0] pat_q, pat_d;
  logic [DATA_BIT-1:0] freq_q, freq_d;
  cmd_cfg_t            cfg_q, cfg_d;
  cmd_cfg_t            in_cfg;
  logic                serial_q, serial_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load, tmr_en, tmr_zero, tmr_zero_nxt;
  logic [PERIOD_W-1:0] tmr_val, tmr_cnt;

  logic cmd_acc, cmd_stop, cmd_start, cmd_cfg;

`ifdef DIFF_FREQ_SHADOW_EN
  logic [DATA_BIT-1:0] sh_pat_q, sh_pat_d;
  logic [DATA_BIT-1:0] sh_freq_q, sh_freq_d;
  cmd_cfg_t            sh_cfg_q, sh_cfg_d;
  logic                pend_q, pend_d;
`endif

  assign in_cfg    = {i_mode, i_slow_period, i_fast_period};
  assign cmd_acc   = i_done_tick && (i_sel_out == SEL_W'(CHANNEL_ID));
  assign cmd_stop  = cmd_acc && i_stop;
  assign cmd_start = cmd_acc && !i_stop && i_start;
  assign cmd_cfg   = cmd_acc && !i_stop && !i_start;

  bit_timer u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  // Value the timer's zero flag will take after this edge (used to look ahead for done)
  assign tmr_zero_nxt = tmr_load ? (tmr_val == '0) : (tmr_en && (tmr_cnt == PERIOD_W'(1)));

  // Next-state, working-register and output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pat_d    = pat_q;
    freq_d   = freq_q;
    cfg_d    = cfg_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    serial_d = IDLE_LEVEL;
    busy_d   = 1'b0;
    done_d   = 1'b0;
`ifdef DIFF_FREQ_SHADOW_EN
    sh_pat_d  = sh_pat_q;
    sh_freq_d = sh_freq_q;
    sh_cfg_d  = sh_cfg_q;
    pend_d    = pend_q;
`endif

    if (cmd_stop) begin
      state_d = S_IDLE;
`ifdef DIFF_FREQ_SHADOW_EN
      pend_d  = 1'b0;
`endif
    end else if (cmd_start) begin
      pat_d    = i_output_pattern;
      freq_d   = i_freq_pattern;
      cfg_d    = in_cfg;
      state_d  = S_RUN;
      idx_d    = '0;
      tmr_load = 1'b1;
      tmr_val  = i_freq_pattern[0] ? i_fast_period : i_slow_period;
`ifdef DIFF_FREQ_SHADOW_EN
      pend_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
`ifdef DIFF_FREQ_SHADOW_EN
          if (cmd_cfg) begin
            sh_pat_d  = i_output_pattern;
            sh_freq_d = i_freq_pattern;
            sh_cfg_d  = in_cfg;
            pend_d    = 1'b1;
          end
`endif
          if (!tmr_zero) begin
            tmr_en = 1'b1;
          end else if (idx_q != IDX_LAST) begin
            idx_d    = idx_q + IDX_W'(1);
            tmr_load = 1'b1;
            tmr_val  = freq_q[idx_d] ? cfg_q.fast : cfg_q.slow;
          end else if (cfg_q.mode) begin
`ifdef DIFF_FREQ_SHADOW_EN
            // Pending shadow set (including one arriving this very edge) takes effect on wrap
            if (pend_d) begin
              pat_d  = sh_pat_d;
              freq_d = sh_freq_d;
              cfg_d  = sh_cfg_d;
              pend_d = 1'b0;
            end
`endif
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = freq_d[0] ? cfg_d.fast : cfg_d.slow;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          if (cmd_cfg) begin
            pat_d  = i_output_pattern;
            freq_d = i_freq_pattern;
            cfg_d  = in_cfg;
`ifdef DIFF_FREQ_SHADOW_EN
            pend_d = 1'b0;
`endif
          end
        end
        default: begin
          if (cmd_cfg) begin
            pat_d  = i_output_pattern;
            freq_d = i_freq_pattern;
            cfg_d  = in_cfg;
`ifdef DIFF_FREQ_SHADOW_EN
            pend_d = 1'b0;
`endif
          end
        end
      endcase
    end

    if (state_d == S_RUN) begin
      busy_d   = 1'b1;
      serial_d = pat_d[idx_d];
      // Continuous mode: done pulses together with the bit tick of the final bit
      if (cfg_d.mode && (idx_d == IDX_LAST) && tmr_zero_nxt) done_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      pat_q    <= '0;
      freq_q   <= '0;
      cfg_q    <= '0;
      serial_q <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pat_q    <= pat_d;
      freq_q   <= freq_d;
      cfg_q    <= cfg_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef DIFF_FREQ_SHADOW_EN
  // Shadow set for config updates received mid-run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_pat_q  <= '0;
      sh_freq_q <= '0;
      sh_cfg_q  <= '0;
      pend_q    <= 1'b0;
    end else begin
      sh_pat_q  <= sh_pat_d;
      sh_freq_q <= sh_freq_d;
      sh_cfg_q  <= sh_cfg_d;
      pend_q    <= pend_d;
    end
  end
`endif

  assign o_serial_out = serial_q;
  assign o_bit_tick   = tmr_zero;
  assign o_busy       = busy_q;
  assign o_done_tick  = done_q;

endmodule

// File: tb/tb_diff_freq_channel.sv
// Directed testbench for diff_freq_channel: a 32-bit instance (channel 0) and an
// 8-bit instance (channel 2) share one command bus.
module tb_diff_freq_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_tick;
  logic [31:0] pat, freq;
  logic [3:0]  sel;
  logic        start, stop, mode;
  logic [7:0]  slow, fast;

  logic a_serial, a_bit, a_busy, a_done;
  logic b_serial, b_bit, b_busy, b_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  diff_freq_channel #(.DATA_BIT(32), .CHANNEL_ID(0), .IDLE_LEVEL(1'b0)) u_dut32 (
    .clk(clk), .rst(rst), .i_done_tick(done_tick),
    .i_output_pattern(pat), .i_freq_pattern(freq), .i_sel_out(sel),
    .i_start(start), .i_stop(stop), .i_mode(mode),
    .i_slow_period(slow), .i_fast_period(fast),
    .o_serial_out(a_serial), .o_bit_tick(a_bit), .o_busy(a_busy), .o_done_tick(a_done)
  );

  diff_freq_channel #(.DATA_BIT(8), .CHANNEL_ID(2), .IDLE_LEVEL(1'b0)) u_dut8 (
    .clk(clk), .rst(rst), .i_done_tick(done_tick),
    .i_output_pattern(pat[7:0]), .i_freq_pattern(freq[7:0]), .i_sel_out(sel),
    .i_start(start), .i_stop(stop), .i_mode(mode),
    .i_slow_period(slow), .i_fast_period(fast),
    .o_serial_out(b_serial), .o_bit_tick(b_bit), .o_busy(b_busy), .o_done_tick(b_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one decoder strobe; returns sampling cycle 1 after the accepting edge
  task automatic send(input logic [3:0] s, input logic [31:0] p, input logic [31:0] f,
                      input logic st, input logic sp, input logic m,
                      input logic [7:0] sl, input logic [7:0] fs);
    @(negedge clk);
    sel = s; pat = p; freq = f; start = st; stop = sp; mode = m;
    slow = sl; fast = fs; done_tick = 1'b1;
    @(posedge clk);
    #1;
    done_tick = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] a5;
    int first_done, second_done, exp_second;
    a5 = 8'hA5;
    rst = 1'b1; done_tick = 1'b0; pat = '0; freq = '0; sel = '0;
    start = 1'b0; stop = 1'b0; mode = 1'b0; slow = '0; fast = '0;

    // Reset state
    step();
    check_val("rst_serial", a_serial, 0);
    check_val("rst_bit", a_bit, 0);
    check_val("rst_busy", a_busy, 0);
    check_val("rst_done", a_done, 0);
    @(negedge clk) rst = 1'b0;
    step();

    // Address filter: channel 3 matches neither instance
    send(4'd3, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) step();
      check_val("filt_a_busy", a_busy, 0);
      check_val("filt_a_serial", a_serial, 0);
      check_val("filt_b_busy", b_busy, 0);
    end

    // One-shot mixed timing on the 32-bit channel
    send(4'd0, 32'h0000_0005, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 8'd3, 8'd1);
    for (int c = 1; c <= 128; c++) begin
      if (c > 1) step();
      check_val("os_serial", a_serial, ((c <= 2) || (c >= 7 && c <= 10)) ? 1 : 0);
      check_val("os_busy", a_busy, (c <= 126) ? 1 : 0);
      check_val("os_bit", a_bit, ((c <= 126) && (c == 2 || (c > 2 && (c - 2) % 4 == 0))) ? 1 : 0);
      check_val("os_done", a_done, (c == 127) ? 1 : 0);
    end

    // Continuous mode on the 8-bit channel, 1-clock bits
    send(4'd2, 32'h0000_00A5, 32'h0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) step();
      check_val("cont_serial", b_serial, a5[(c - 1) % 8]);
      check_val("cont_bit", b_bit, 1);
      check_val("cont_done", b_done, (c % 8 == 0) ? 1 : 0);
      check_val("cont_busy", b_busy, 1);
    end
    check_val("cont_other_idle", a_busy, 0);
    send(4'd2, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    check_val("cont_stop_busy", b_busy, 0);
    check_val("cont_stop_done", b_done, 0);

    // Stop wins over start mid-run, then a clean restart
    send(4'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0);
    repeat (4) step();
    check_val("ss_run_serial", a_serial, 1);
    check_val("ss_run_busy", a_busy, 1);
    send(4'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0, 8'd3, 8'd0);
    check_val("ss_serial", a_serial, 0);
    check_val("ss_busy", a_busy, 0);
    check_val("ss_done", a_done, 0);
    step();
    check_val("ss_done2", a_done, 0);
    send(4'd0, 32'h0000_0001, 32'h0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
    check_val("rs_serial_c1", a_serial, 1);
    check_val("rs_busy_c1", a_busy, 1);
    repeat (2) step();
    check_val("rs_serial_c3", a_serial, 1);
    step();
    check_val("rs_serial_c4", a_serial, 0);
    send(4'd0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

    // Config-only during a continuous run with 2-cycle slow bits
    send(4'd2, 32'h0000_000F, 32'h0, 1'b1, 1'b0, 1'b1, 8'd1, 8'd0);
    repeat (2) step();
    send(4'd2, 32'h0000_000F, 32'h0, 1'b0, 1'b0, 1'b1, 8'd7, 8'd0);
    first_done = 0;
    second_done = 0;
    for (int c = 4; c <= 200; c++) begin
      if (c > 4) step();
      if (b_done) begin
        if (first_done == 0) first_done = c;
        else begin
          second_done = c;
          break;
        end
      end
    end
`ifdef DIFF_FREQ_SHADOW_EN
    exp_second = 80;
`else
    exp_second = 32;
`endif
    check_val("shadow_first_done", 32'(first_done), 32'd16);
    check_val("shadow_second_done", 32'(second_done), 32'(exp_second));
    send(4'd2, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

    // Asynchronous reset during bit 5
    send(4'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
    repeat (10) step();
    check_val("rm_busy_before", a_busy, 1);
    check_val("rm_serial_before", a_serial, 1);
    rst = 1'b1;
    #1;
    check_val("rm_serial", a_serial, 0);
    check_val("rm_bit", a_bit, 0);
    check_val("rm_busy", a_busy, 0);
    check_val("rm_done", a_done, 0);
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_val("rm_post_busy", a_busy, 0);
      check_val("rm_post_done", a_done, 0);
      check_val("rm_post_serial", a_serial, 0);
    end
    send(4'd0, 32'h0000_0001, 32'h0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    check_val("rm_restart_busy", a_busy, 1);
    check_val("rm_restart_serial", a_serial, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
